// File: rtl/bist_lfsr_misr_ctrl.sv
// -----------------------------------------------------------------------------
// bist_lfsr_misr_ctrl
//
// Self-contained BIST engine for a combinational circuit under test (CUT).
// Two Galois LFSRs generate operands A and B, and a wrapping counter sweeps the
// opcode select. Each CUT response is folded into a MISR. When the run ends,
// the signature is compared against GOLDEN_SIG.
//
// Optional feature macro: BIST_FAIL_CAPTURE_EN
//   When defined, the engine also compares every response against exp_resp.
//   It counts mismatches, records the index of the first one, and qualifies
//   pass with "no mismatch seen".
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous, active-high reset
//   start          in   begin a run (sampled in IDLE or DONE only)
//   abort          in   terminate a run (honoured in RUN only, wins over start)
//   pat_a/pat_b    out  DATA_W operands to CUT
//   pat_sel        out  SEL_W opcode select to CUT (wraps)
//   resp           in   RESP_W CUT response, combinational from pat_*
//   busy           out  high in RUN
//   done           out  high in DONE
//   pass           out  valid with done: signature matched (and no capture fail)
//   signature      out  RESP_W current MISR contents
//   pat_idx        out  CNT_W index of the pattern currently applied
//   exp_resp       in   RESP_W expected response     (BIST_FAIL_CAPTURE_EN)
//   fail_cnt       out  CNT_W saturating mismatch count (BIST_FAIL_CAPTURE_EN)
//   first_fail_idx out  CNT_W pat_idx of first mismatch (BIST_FAIL_CAPTURE_EN)
//   fail_seen      out  at least one mismatch this run (BIST_FAIL_CAPTURE_EN)
// -----------------------------------------------------------------------------
module bist_lfsr_misr_ctrl #(
    parameter int                  DATA_W     = 8,
    parameter int                  SEL_W      = 4,
    parameter int                  RESP_W     = 9,
    parameter int                  NUM_PAT    = 256,
    parameter int                  CNT_W      = 16,
    parameter logic [DATA_W-1:0]   POLY_A     = 8'hB8,
    parameter logic [DATA_W-1:0]   POLY_B     = 8'hB8,
    parameter logic [DATA_W-1:0]   SEED_A     = 8'h01,
    parameter logic [DATA_W-1:0]   SEED_B     = 8'h5A,
    parameter logic [RESP_W-1:0]   MISR_POLY  = 9'h110,
    parameter logic [RESP_W-1:0]   GOLDEN_SIG = 9'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [DATA_W-1:0] pat_a,
    output logic [DATA_W-1:0] pat_b,
    output logic [SEL_W-1:0]  pat_sel,
    input  logic [RESP_W-1:0] resp,
`ifdef BIST_FAIL_CAPTURE_EN
    input  logic [RESP_W-1:0] exp_resp,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic              fail_seen,
`endif
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [RESP_W-1:0] signature,
    output logic [CNT_W-1:0]  pat_idx
);

    // An all-zero seed would lock a Galois LFSR at zero forever, so it is
    // replaced by 1.
    localparam logic [DATA_W-1:0] SEED_A_EFF = (SEED_A == '0) ? DATA_W'(1) : SEED_A;
    localparam logic [DATA_W-1:0] SEED_B_EFF = (SEED_B == '0) ? DATA_W'(1) : SEED_B;
    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(NUM_PAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    // Control decoded from the state machine.
    logic load;        // reload seeds and clear the signature (run start)
    logic step;        // absorb resp and advance the pattern generators
    logic enter_done;  // final absorb edge: latch the pass verdict

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s,
                                                    input logic [DATA_W-1:0] poly);
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        step       = 1'b0;
        enter_done = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over everything else; start is ignored in RUN.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (pat_idx == LAST_IDX) begin
                        enter_done = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    logic [RESP_W-1:0] sig_next;
    assign sig_next = (signature >> 1) ^ (signature[0] ? MISR_POLY : '0) ^ resp;

    // The last absorb edge freezes the pattern outputs so that pat_idx reports
    // the final pattern while the engine is in DONE.
    logic advance;
    assign advance = step && !enter_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_a     <= SEED_A_EFF;
            pat_b     <= SEED_B_EFF;
            pat_sel   <= '0;
            pat_idx   <= '0;
            signature <= '0;
        end else if (load) begin
            pat_a     <= SEED_A_EFF;
            pat_b     <= SEED_B_EFF;
            pat_sel   <= '0;
            pat_idx   <= '0;
            signature <= '0;
        end else begin
            if (step) signature <= sig_next;
            if (advance) begin
                pat_a   <= lfsr_step(pat_a, POLY_A);
                pat_b   <= lfsr_step(pat_b, POLY_B);
                pat_sel <= pat_sel + SEL_W'(1);
                pat_idx <= pat_idx + CNT_W'(1);
            end
        end
    end

`ifdef BIST_FAIL_CAPTURE_EN
    logic mismatch;
    assign mismatch = step && (resp != exp_resp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
        end else if (load) begin
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
        end else if (mismatch) begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            if (!fail_seen) begin
                first_fail_idx <= pat_idx;
                fail_seen      <= 1'b1;
            end
        end
    end

    // The verdict includes a mismatch seen on the final absorb edge itself.
    logic pass_d;
    assign pass_d = (sig_next == GOLDEN_SIG) && !(fail_seen || mismatch);
`else
    logic pass_d;
    assign pass_d = (sig_next == GOLDEN_SIG);
`endif

    // pass is cleared on each run start. It stays 0 through RUN and any abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           pass <= 1'b0;
        else if (load)       pass <= 1'b0;
        else if (enter_done) pass <= pass_d;
    end

endmodule

// File: doc/bist_lfsr_misr_ctrl.md
Name: bist_lfsr_misr_ctrl

Overview:
- Self-contained BIST engine for a combinational CUT such as the 8-bit ALU.
- Two Galois LFSRs drive operands A and B, and a counter sweeps the opcode select.
- Each CUT response is compressed into a MISR signature; at run end the signature is compared against a golden value.
- Successor to the fixed 8-bit generator/ROM-compare bench: parametrised widths, pattern count and polynomials, with a start/done handshake and abort.

Parameters:
DATA_W, 8, operand width of pat_a/pat_b
SEL_W, 4, opcode select width; pat_sel wraps mod 2^SEL_W
RESP_W, 9, CUT response width ({ALU_Out, CarryOut})
NUM_PAT, 256, patterns applied per run (>=1)
CNT_W, 16, pattern counter width (2^CNT_W > NUM_PAT)
POLY_A, 8'hB8, Galois right-shift tap mask for LFSR A
POLY_B, 8'hB8, tap mask for LFSR B
SEED_A, 8'h01, LFSR A seed
SEED_B, 8'h5A, LFSR B seed
MISR_POLY, 9'h110, MISR tap mask
GOLDEN_SIG, 9'h000, expected final signature

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  begin a run; sampled only in IDLE or DONE
abort  in  1  terminate a run; honoured only in RUN
pat_a  out  DATA_W  operand A to CUT
pat_b  out  DATA_W  operand B to CUT
pat_sel  out  SEL_W  opcode select to CUT
resp  in  RESP_W  CUT response, combinational from pat_*
busy  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  valid when done=1: signature==GOLDEN_SIG
signature  out  RESP_W  current MISR contents
pat_idx  out  CNT_W  index of the pattern currently applied

Behaviour:
- Reset: state=IDLE; pat_a=SEED_A, pat_b=SEED_B, pat_sel=0, signature=0, pat_idx=0, busy=0, done=0, pass=0.
- A seed of all zeros is illegal. The implementation substitutes 1 for it.
- LFSR step, where s is the register and P its tap mask: s_next = (s>>1) ^ (s[0] ? P : 0).
- MISR step: sig_next = (sig>>1) ^ (sig[0] ? MISR_POLY : 0) ^ resp.
- IDLE: outputs hold. When start=1 at a clock edge:
  - load seeds, pat_sel=0, signature=0, pat_idx=0;
  - go to RUN.
- RUN, every edge:
  - MISR absorbs resp for the current pattern.
  - Both LFSRs step, pat_sel increments (wraps), pat_idx increments.
  - The edge that absorbs pattern NUM_PAT-1 goes to DONE and freezes pat_*/pat_idx.
  - Exactly NUM_PAT responses are compressed.
  - done rises after the NUM_PAT-th edge following the start edge.
- DONE: done=1; pass=(signature==GOLDEN_SIG), registered on the DONE entry edge. Both hold until start=1, which reloads as in IDLE and goes to RUN (done and pass drop the same edge).
- start while in RUN: ignored.
- abort=1 in RUN:
  - go to IDLE next edge; the response on that edge is not absorbed;
  - done=0, pass=0; signature holds for debug.
  - If abort and start are both high in RUN, abort wins.
- LFSR period is 2^DATA_W-1 for primitive masks. For NUM_PAT above the period, patterns repeat and no stall occurs.
- Asynchronous reset mid-RUN: immediately returns to the reset state; no partial done.

Optional Feature:
- Macro: BIST_FAIL_CAPTURE_EN.
- When defined, extra ports are added:
  - exp_resp in RESP_W: expected response, e.g. from the golden ROM indexed by pat_idx;
  - fail_cnt out CNT_W;
  - first_fail_idx out CNT_W;
  - fail_seen out 1.
- On each RUN absorb edge with resp!=exp_resp:
  - fail_cnt increments, saturating;
  - on the first mismatch, first_fail_idx=pat_idx and fail_seen=1.
- All three clear on reset and on a run start, and hold in DONE/IDLE.
- pass becomes (signature==GOLDEN_SIG) && !fail_seen.
- Without the macro, these ports and logic are absent and pass is signature-only.

Test Plan:
- Reset, then start pulse with defaults -> pat_a sequence 01,B8,5C,2E,17,B3 on consecutive RUN cycles; pat_sel 0,1,2,3,4,5; busy=1.
- Full run, fault-free ALU model, GOLDEN_SIG set to the bench-model signature -> done=1 exactly 256 edges after the start edge, pass=1, pat_idx=255, busy=0.
- Same run with resp[0] stuck-at-1 -> pass=0. With BIST_FAIL_CAPTURE_EN: fail_seen=1 and first_fail_idx = first index whose true carry=0.
- After 20 patterns in RUN, start=1 -> ignored. Then abort=1 at pattern 40 -> IDLE next edge, done=0, signature holds the value after 40 absorbs.
- Abort and start together in RUN -> IDLE. Start in DONE -> new RUN, done/pass drop, signature restarts from 0.
- Assert reset at pattern 100 -> all outputs return to reset values asynchronously. A later start produces a run identical to the first run.
